// File: rtl/lcd_queue_ctrl.sv
// rtl/lcd_queue_ctrl.sv - queued LCD panel writer behind a custom-instruction port (optional macro LCD_LONG_CMD_EN)
module lcd_queue_ctrl #(
  parameter int DEPTH     = 16,
  parameter int SETUP_CYC = 1316,
  parameter int HOLD_CYC  = 54001,
  parameter int LONG_CYC  = 82000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic [7:0]  lcd_data,
  output logic        busy
);

  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW      = $clog2(DEPTH + 1);
  localparam int MAX_AB  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_CYC = (LONG_CYC > MAX_AB) ? LONG_CYC : MAX_AB;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_lcd_en;
  logic            r_lcd_rs;
  logic [7:0]      r_lcd_data;
  logic [LW-1:0]   r_level;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [8:0]      r_mem [DEPTH];
  logic            r_done;
  logic [31:0]     r_result;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_en_nxt;
  logic            w_pop;
  logic            w_accept;
  logic            w_query;
  logic            w_full;
  logic            w_push;
  logic            w_busy;
  logic [LW-1:0]   w_level_nxt;
  logic [CW-1:0]   w_hold_last;
  logic            w_unused;

  assign w_accept    = clk_en & start;
  assign w_query     = dataa[1];
  // Fullness uses the level at the start of the cycle, so a same-cycle pop never frees room.
  assign w_full      = (r_level == LW'(DEPTH));
  assign w_push      = w_accept & ~w_query & ~w_full;
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
  assign w_busy      = (r_level != '0) | (r_state != S_IDLE);
  assign w_unused    = ^{dataa[31:2], datab[31:8]};

`ifdef LCD_LONG_CMD_EN
  logic w_long;
  // Clear/home style commands need a longer settle time on the panel.
  assign w_long      = ~r_lcd_rs & ((r_lcd_data == 8'h01) | (r_lcd_data == 8'h02) |
                                    (r_lcd_data == 8'h03));
  assign w_hold_last = w_long ? CW'(LONG_CYC - 1) : CW'(HOLD_CYC - 1);
`else
  assign w_hold_last = CW'(HOLD_CYC - 1);
`endif

  // Drain FSM next-state: pop in IDLE, count SETUP then HOLD, lcd_en low only in HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_en_nxt    = r_lcd_en;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = '0;
          w_en_nxt    = 1'b1;
        end
      end
      S_SETUP: begin
        if (r_cnt == CW'(SETUP_CYC - 1)) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_en_nxt    = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == w_hold_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_en_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_en_nxt    = 1'b1;
      end
    endcase
  end

  // Drain FSM state, counter and enable line; runs every cycle independent of clk_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_lcd_en <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_lcd_en <= w_en_nxt;
    end
  end

  // FIFO pointers and level; reset discards every queued entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_level <= w_level_nxt;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  // FIFO storage; contents are meaningless outside the pointer window, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {dataa[0], datab[7:0]};
  end

  // Panel rs/data latch the popped head and stay stable until the next pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lcd_rs   <= 1'b0;
      r_lcd_data <= 8'h00;
    end else if (w_pop) begin
      {r_lcd_rs, r_lcd_data} <= r_mem[r_rptr];
    end
  end

  // CPU side: one-cycle done after each accepted instruction, result held until the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done   <= 1'b0;
      r_result <= 32'h0;
    end else begin
      r_done <= w_accept;
      if (w_accept) begin
        if (w_query)     r_result <= {22'b0, ~w_busy, 9'(r_level)};
        else if (w_full) r_result <= 32'hFFFF_FFFF;
        else             r_result <= 32'(w_level_nxt);
      end
    end
  end

  assign done     = r_done;
  assign result   = r_result;
  assign lcd_rs   = r_lcd_rs;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = r_lcd_en;
  assign lcd_data = r_lcd_data;
  assign busy     = w_busy;

endmodule

// File: tb/tb_lcd_queue_ctrl.sv
// tb/tb_lcd_queue_ctrl.sv - self-checking bench for lcd_queue_ctrl with a timeline model
module tb_lcd_queue_ctrl;

  localparam int DEPTH = 4;
  localparam int SETUP = 4;
  localparam int HOLD  = 10;
  localparam int LONG  = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dataa = 32'h0;
  logic [31:0] datab = 32'h0;
  logic        done;
  logic [31:0] result;
  logic        lcd_rs, lcd_rw, lcd_en, busy;
  logic [7:0]  lcd_data;

  int n_pass = 0;
  int n_total = 0;

  lcd_queue_ctrl #(.DEPTH(DEPTH), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .LONG_CYC(LONG)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa), .datab(datab),
    .done(done), .result(result), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int hold_for(input logic rs, input logic [7:0] b);
`ifdef LCD_LONG_CMD_EN
    if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) return LONG;
`endif
    return HOLD;
  endfunction

  // Model: queue of entries plus a timeline of when the current transfer's enable falls/rises.
  logic [8:0]  mq[$];
  logic [8:0]  m_ent;
  int          m_now = 0, m_fall = 0, m_rise = 0, m_free = 0, m_pre_lvl = 0;
  bit          m_pre_busy, m_valid = 0;
  logic        m_done = 1'b0, m_rs = 1'b0;
  logic [7:0]  m_data = 8'h0;
  logic [31:0] m_res = 32'h0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_now = 0; m_fall = 0; m_rise = 0; m_free = 0;
      m_done = 1'b0; m_res = 32'h0; m_rs = 1'b0; m_data = 8'h0;
      m_valid = 1;
    end else begin
      m_pre_lvl  = mq.size();
      m_pre_busy = (m_pre_lvl > 0) || (m_now < m_free);
      m_done     = clk_en && start;
      if (m_now >= m_free && m_pre_lvl > 0) begin
        m_ent  = mq.pop_front();
        m_rs   = m_ent[8];
        m_data = m_ent[7:0];
        m_fall = m_now + 1 + SETUP;
        m_rise = m_fall + hold_for(m_rs, m_data);
        m_free = m_rise;
      end
      if (clk_en && start) begin
        if (dataa[1]) m_res = {22'b0, !m_pre_busy, 9'(m_pre_lvl)};
        else if (m_pre_lvl == DEPTH) m_res = 32'hFFFF_FFFF;
        else begin
          mq.push_back({dataa[0], datab[7:0]});
          m_res = 32'(mq.size());
        end
      end
      m_now++;
    end
  end

  // Every cycle: compare all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("m_done", 32'(done), 32'(m_done));
      check("m_result", result, m_res);
      check("m_lcd_en", 32'(lcd_en), 32'(!(m_now >= m_fall && m_now < m_rise)));
      check("m_lcd_rs", 32'(lcd_rs), 32'(m_rs));
      check("m_lcd_data", 32'(lcd_data), 32'(m_data));
      check("m_busy", 32'(busy), 32'((mq.size() > 0) || (m_now < m_free)));
      check("m_lcd_rw", 32'(lcd_rw), 32'h0);
    end
  end

  // Panel monitor: byte latched at every falling edge of lcd_en.
  logic [7:0] panel[$];
  logic       prev_en = 1'b1;
  always @(negedge clk) begin
    if (prev_en && !lcd_en) panel.push_back(lcd_data);
    prev_en = lcd_en;
  end

  logic        b_op [8];
  logic        b_rs [8];
  logic [7:0]  b_byte [8];
  logic [31:0] b_res [8];

  // Issue n instructions in consecutive cycles; capture each result in its done cycle.
  task automatic burst(input int n);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      clk_en = 1'b1; start = 1'b1;
      dataa = {30'b0, b_op[i], b_rs[i]};
      datab = {24'b0, b_byte[i]};
      @(posedge clk); #1;
      if (i == n - 1) begin clk_en = 1'b0; start = 1'b0; end
      @(negedge clk);
      b_res[i] = result;
      check("burst_done", 32'(done), 32'h1);
    end
  endtask

  task automatic set_b(input int i, input logic op, input logic rs, input logic [7:0] b);
    b_op[i] = op; b_rs[i] = rs; b_byte[i] = b;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 300) begin @(negedge clk); c++; end
    check("drain_timeout", 32'(busy), 32'h0);
  endtask

  int cnt, idx;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_lcd_en", 32'(lcd_en), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_data", 32'(lcd_data), 32'h0);

    // Single push: data two cycles after the push, fall 4 later, busy clears 10 after the fall.
    set_b(0, 1'b0, 1'b1, 8'h41);
    burst(1);
    check("push1_result", b_res[0], 32'h1);
    @(negedge clk);
    check("push1_data", 32'(lcd_data), 32'h41);
    check("push1_rs", 32'(lcd_rs), 32'h1);
    check("push1_en", 32'(lcd_en), 32'h1);
    cnt = 0;
    while (lcd_en && cnt < 50) begin @(negedge clk); cnt++; end
    check("setup_len", cnt, 4);
    cnt = 0;
    while (busy && cnt < 100) begin @(negedge clk); cnt++; end
    check("hold_len", cnt, 10);

    // Overflow: five pushes while the drain sits in HOLD.
    idx = panel.size();
    set_b(0, 1'b0, 1'b1, 8'h50);
    burst(1);
    cnt = 0;
    while (lcd_en && cnt < 50) begin @(negedge clk); cnt++; end
    for (int i = 0; i < 5; i++) set_b(i, 1'b0, 1'b1, 8'h61 + 8'(i));
    burst(5);
    check("ovf_r0", b_res[0], 32'h1);
    check("ovf_r1", b_res[1], 32'h2);
    check("ovf_r2", b_res[2], 32'h3);
    check("ovf_r3", b_res[3], 32'h4);
    check("ovf_r4", b_res[4], 32'hFFFF_FFFF);
    wait_idle();
    check("ovf_count", panel.size() - idx, 5);
    if (panel.size() - idx == 5) begin
      check("ovf_b0", 32'(panel[idx]), 32'h50);
      for (int i = 0; i < 4; i++) check("ovf_bytes", 32'(panel[idx + 1 + i]), 32'h61 + i);
    end

    // Query with two queued while in SETUP, then after drain.
    set_b(0, 1'b0, 1'b1, 8'h31);
    set_b(1, 1'b0, 1'b1, 8'h32);
    set_b(2, 1'b0, 1'b1, 8'h33);
    set_b(3, 1'b1, 1'b0, 8'h00);
    burst(4);
    check("q_setup", b_res[3], 32'h0000_0002);
    wait_idle();
    set_b(0, 1'b1, 1'b0, 8'h00);
    burst(1);
    check("q_idle", b_res[0], 32'h0000_0200);

    // Command 0x01: HOLD length depends on the long-command option.
    set_b(0, 1'b0, 1'b0, 8'h01);
    burst(1);
    cnt = 0;
    while (lcd_en && cnt < 50) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (!lcd_en && cnt < 100) begin @(negedge clk); cnt++; end
`ifdef LCD_LONG_CMD_EN
    check("cmd_hold", cnt, LONG);
`else
    check("cmd_hold", cnt, HOLD);
`endif
    wait_idle();

    // Reset during SETUP with three queued: nothing further reaches the panel.
    for (int i = 0; i < 4; i++) set_b(i, 1'b0, 1'b1, 8'h71 + 8'(i));
    burst(4);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_en", 32'(lcd_en), 32'h1);
    check("rst_mid_busy", 32'(busy), 32'h0);
    idx = panel.size();
    repeat (40) @(negedge clk);
    check("rst_no_fall", panel.size() - idx, 0);
    set_b(0, 1'b1, 1'b0, 8'h00);
    burst(1);
    check("rst_level", b_res[0], 32'h0000_0200);

    // clk_en low gates the CPU port while a queued byte still drains.
    idx = panel.size();
    set_b(0, 1'b0, 1'b1, 8'h5A);
    burst(1);
    @(posedge clk); #1;
    clk_en = 1'b0; start = 1'b1; dataa = 32'h1; datab = 32'hA5;
    cnt = 0;
    repeat (6) begin @(negedge clk); if (done) cnt++; end
    @(posedge clk); #1 start = 1'b0;
    check("gated_done", cnt, 0);
    wait_idle();
    check("gated_panel_n", panel.size() - idx, 1);
    if (panel.size() - idx == 1) check("gated_byte", 32'(panel[idx]), 32'h5A);
    set_b(0, 1'b1, 1'b0, 8'h00);
    burst(1);
    check("gated_level", b_res[0], 32'h0000_0200);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
